// File: rtl/bw_tester_pkg.sv
// Shared definitions for the bandwidth tester AXI4-Lite register block:
// register map, CTRL/STATUS bit positions, response codes and reset FSM states.
package bw_tester_pkg;

  localparam int BWT_REG_CTRL         = 'h00;
  localparam int BWT_REG_STATUS       = 'h04;
  localparam int BWT_REG_SHADOW_FIRST = 'h08;
  localparam int BWT_REG_SHADOW_LAST  = 'h28;
  localparam int BWT_REG_ID           = 'h2C;

  localparam int BWT_NUM_SHADOWS = 9;

  localparam int BWT_CTRL_TRIGGER  = 0;
  localparam int BWT_CTRL_RESET    = 1;
  localparam int BWT_CTRL_SNAPSHOT = 2;
  localparam int BWT_CTRL_RUNNING  = 0;
  localparam int BWT_CTRL_PENDING  = 1;

  localparam int BWT_STAT_OVERFLOW  = 0;
  localparam int BWT_STAT_UNDERFLOW = 1;
  localparam int BWT_STAT_TIMEOUT   = 2;

  localparam logic [1:0] BWT_RESP_OKAY   = 2'b00;
  localparam logic [1:0] BWT_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } bwt_rst_state_t;

  // Everything from CTRL up to and including ID is decoded; the rest is a hole.
  function automatic logic bwt_is_mapped(input logic [3:0] word);
    return word <= 4'(BWT_REG_ID / 4);
  endfunction

endpackage

// File: rtl/bwt_rst_handshake.sv
// Reset request/acknowledge handshake towards the tester, with a timeout
// that abandons the request if the acknowledge never arrives.
module bwt_rst_handshake
  import bw_tester_pkg::*;
#(
  parameter int C_RST_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic reset_ack,
  output logic reset_timer,
  output logic pending,
  output logic done,
  output logic timed_out
);

  localparam int CW = (C_RST_TIMEOUT > 1) ? $clog2(C_RST_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(C_RST_TIMEOUT - 1);

  bwt_rst_state_t state, state_next;
  logic [CW-1:0]  cnt, cnt_next;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          cnt_next   = '0;
        end
      end
      REQ: begin
        if (reset_ack) begin
          state_next = WAIT_LOW;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          done       = 1'b1;
          timed_out  = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      WAIT_LOW: begin
        if (!reset_ack) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign reset_timer = (state == REQ);
  assign pending     = (state != IDLE);

endmodule

// File: rtl/bw_tester_axil_regs.sv
// AXI4-Lite register file in front of the bandwidth tester: control commands,
// sticky FIFO error flags, coherent result snapshots and the ID register.
module bw_tester_axil_regs
  import bw_tester_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter int          C_RST_TIMEOUT      = 16,
  parameter logic [31:0] C_ID_VALUE         = 32'hB37E5701
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            trigger,
  output logic                            reset_timer,
  input  logic                            reset_ack,
  input  logic [31:0]                     timer,
  input  logic [31:0]                     s2mm_wlast_timer_reg,
  input  logic [31:0]                     s2mm_stream_timer_reg,
  input  logic [31:0]                     s2mm_wlast_count,
  input  logic [31:0]                     s2mm_stream_count,
  input  logic [31:0]                     mm2s_arwalid_timer_reg,
  input  logic [31:0]                     mm2s_stream_timer_reg,
  input  logic [31:0]                     mm2s_tlast_count,
  input  logic [31:0]                     mm2s_stream_count,
  input  logic                            fifo_overflow,
  input  logic                            fifo_underflow
);

  localparam logic [3:0] W_CTRL         = 4'(BWT_REG_CTRL / 4);
  localparam logic [3:0] W_STATUS       = 4'(BWT_REG_STATUS / 4);
  localparam logic [3:0] W_SHADOW_FIRST = 4'(BWT_REG_SHADOW_FIRST / 4);
  localparam logic [3:0] W_SHADOW_LAST  = 4'(BWT_REG_SHADOW_LAST / 4);
  localparam logic [3:0] W_ID           = 4'(BWT_REG_ID / 4);

  logic        aw_w_ready, wr_en, rd_en;
  logic [3:0]  wr_word, rd_word, shadow_idx;
  logic        wr_ctrl, wr_status, cmd_trigger, cmd_reset, cmd_snap;
  logic [2:0]  w1c;
  logic        snap_pending, running;
  logic [2:0]  sticky;
  logic        rst_pending, rst_done, rst_timed_out;
  logic [31:0] rd_data_next;
  logic [1:0]  rd_resp_next;
  logic [31:0] live   [BWT_NUM_SHADOWS];
  logic [31:0] shadow [BWT_NUM_SHADOWS];

  assign live = '{timer, s2mm_wlast_timer_reg, s2mm_stream_timer_reg, s2mm_wlast_count,
                  s2mm_stream_count, mm2s_arwalid_timer_reg, mm2s_stream_timer_reg,
                  mm2s_tlast_count, mm2s_stream_count};

  assign s_axi_awready = aw_w_ready;
  assign s_axi_wready  = aw_w_ready;

  assign wr_en       = aw_w_ready & s_axi_awvalid & s_axi_wvalid;
  assign rd_en       = s_axi_arready & s_axi_arvalid;
  assign wr_word     = s_axi_awaddr[5:2];
  assign rd_word     = s_axi_araddr[5:2];
  assign wr_ctrl     = wr_en & (wr_word == W_CTRL) & s_axi_wstrb[0];
  assign wr_status   = wr_en & (wr_word == W_STATUS) & s_axi_wstrb[0];
  assign cmd_reset   = wr_ctrl & s_axi_wdata[BWT_CTRL_RESET];
  // A reset request in the same write swallows the trigger.
  assign cmd_trigger = wr_ctrl & s_axi_wdata[BWT_CTRL_TRIGGER] & ~s_axi_wdata[BWT_CTRL_RESET];
  assign cmd_snap    = wr_ctrl & s_axi_wdata[BWT_CTRL_SNAPSHOT];
  assign w1c         = wr_status ? s_axi_wdata[2:0] : 3'b000;

  bwt_rst_handshake #(.C_RST_TIMEOUT(C_RST_TIMEOUT)) u_rst_handshake (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (cmd_reset),
    .reset_ack   (reset_ack),
    .reset_timer (reset_timer),
    .pending     (rst_pending),
    .done        (rst_done),
    .timed_out   (rst_timed_out)
  );

  // While a capture is pending the live inputs are what the shadows are about to hold.
  assign shadow_idx = rd_word - W_SHADOW_FIRST;

  always_comb begin
    rd_data_next = '0;
    rd_resp_next = BWT_RESP_OKAY;
    case (rd_word) inside
      W_CTRL: begin
        rd_data_next[BWT_CTRL_RUNNING] = running;
        rd_data_next[BWT_CTRL_PENDING] = rst_pending;
      end
      W_STATUS: rd_data_next[BWT_STAT_TIMEOUT:BWT_STAT_OVERFLOW] = sticky;
      [W_SHADOW_FIRST:W_SHADOW_LAST]:
        rd_data_next = snap_pending ? live[shadow_idx] : shadow[shadow_idx];
      W_ID: rd_data_next = C_ID_VALUE;
      default: rd_resp_next = BWT_RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_w_ready    <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= BWT_RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= BWT_RESP_OKAY;
      trigger       <= 1'b0;
      snap_pending  <= 1'b0;
      running       <= 1'b0;
      sticky        <= '0;
      // NOTE: the shadows are software-visible, so they are reset even though they are storage.
      for (int i = 0; i < BWT_NUM_SHADOWS; i++) shadow[i] <= '0;
    end else begin
      aw_w_ready    <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~aw_w_ready;
      s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;

      if (wr_en) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= bwt_is_mapped(wr_word) ? BWT_RESP_OKAY : BWT_RESP_SLVERR;
      end else if (s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end

      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data_next;
        s_axi_rresp  <= rd_resp_next;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      trigger      <= cmd_trigger;
      snap_pending <= cmd_snap;
      if (snap_pending) begin
        for (int i = 0; i < BWT_NUM_SHADOWS; i++) shadow[i] <= live[i];
      end

      if (cmd_trigger)   running <= 1'b1;
      else if (rst_done) running <= 1'b0;

      // Set beats clear when both land on the same edge.
      sticky <= (sticky & ~w1c) | {rst_timed_out, fifo_underflow, fifo_overflow};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:3], s_axi_wstrb[3:1]};

endmodule

// File: tb/tb_bw_tester_axil_regs.sv
// Directed plus randomized bench for bw_tester_axil_regs against a behavioural
// register model (plain arrays and flags).
module tb_bw_tester_axil_regs;

  localparam logic [31:0] ID_VALUE = 32'hB37E5701;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        trigger, reset_timer, reset_ack, fifo_overflow, fifo_underflow;
  logic [31:0] res [9];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] shadow_m [9];
  logic        running_m = 1'b0;
  logic        pend_m = 1'b0;
  logic [2:0]  sticky_m = 3'b000;

  // Results of the most recent axi_write
  logic [1:0] last_resp;
  logic       last_trig0, last_trig1, last_rt0, last_rt1, last_aw_early;
  bit         pulse_ovf = 1'b0;

  always #5 clk = ~clk;

  bw_tester_axil_regs dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .trigger(trigger), .reset_timer(reset_timer), .reset_ack(reset_ack),
    .timer(res[0]), .s2mm_wlast_timer_reg(res[1]), .s2mm_stream_timer_reg(res[2]),
    .s2mm_wlast_count(res[3]), .s2mm_stream_count(res[4]), .mm2s_arwalid_timer_reg(res[5]),
    .mm2s_stream_timer_reg(res[6]), .mm2s_tlast_count(res[7]), .mm2s_stream_count(res[8]),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void exp_read(input logic [5:0] addr, output logic [31:0] d, output logic [1:0] r);
    int w = int'(addr) / 4;
    d = 32'h0;
    r = 2'b00;
    if (w == 0)                d = {30'b0, pend_m, running_m};
    else if (w == 1)           d = {29'b0, sticky_m};
    else if (w >= 2 && w <= 10) d = shadow_m[w-2];
    else if (w == 11)          d = ID_VALUE;
    else                       r = 2'b10;
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_delay);
    bit ok = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = (w_delay == 0);
    last_aw_early = 1'b0;
    for (int i = 0; i < w_delay; i++) begin
      @(negedge clk);
      if (awready || wready) last_aw_early = 1'b1;
    end
    wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = awready && wready;
    end
    check("awready_seen", 32'(ok), 32'd1);
    if (pulse_ovf) fifo_overflow = 1'b1;
    @(negedge clk);
    fifo_overflow = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    last_trig0 = trigger; last_rt0 = reset_timer; last_resp = bresp;
    check("bvalid_up", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    last_trig1 = trigger; last_rt1 = reset_timer;
    check("bvalid_down", 32'(bvalid), 32'd0);
  endtask

  task automatic read_check(input string tag, input logic [5:0] addr);
    bit ok = 0;
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = arready;
    end
    check({tag, "_arready"}, 32'(ok), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    d = rdata; r = rresp;
    exp_read(addr, ed, er);
    check(tag, d, ed);
    check({tag, "_resp"}, 32'(r), 32'(er));
    @(negedge clk);
    check({tag, "_stable"}, rdata, ed);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [2:0] v;
    logic [3:0] s;
    rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0; wdata = '0; wstrb = '0; reset_ack = 0;
    fifo_overflow = 0; fifo_underflow = 0;
    for (int i = 0; i < 9; i++) begin res[i] = '0; shadow_m[i] = '0; end
    repeat (3) @(negedge clk);
    check("reset_ctrl_outs", 32'({awready, wready, bvalid, arready, rvalid, trigger, reset_timer}), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_resps", 32'({bresp, rresp}), 32'd0);
    rst_n = 1'b1;
    read_check("rst_ctrl", 6'h00);
    read_check("rst_status", 6'h04);
    read_check("rst_shadow0", 6'h08);
    read_check("id", 6'h2C);

    // Trigger: one-cycle pulse, running set
    axi_write(6'h00, 32'h1, 4'hF, 0);
    check("trig_pulse", 32'({last_trig0, last_trig1}), 32'b10);
    check("trig_resp", 32'(last_resp), 32'd0);
    running_m = 1'b1;
    read_check("ctrl_running", 6'h00);
    axi_write(6'h00, 32'h1, 4'b1110, 0);
    check("trig_no_strb", 32'(last_trig0), 32'd0);

    // Snapshots: first round uses 0x100+i, later rounds random
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 9; i++) res[i] = (r == 0) ? 32'h100 + 32'(i) : $urandom;
      axi_write(6'h00, 32'h4, 4'hF, 0);
      check("snap_no_trig", 32'(last_trig0), 32'd0);
      for (int i = 0; i < 9; i++) begin shadow_m[i] = res[i]; res[i] = $urandom; end
      axi_write(6'(8 + 4 * (r % 9)), $urandom, 4'hF, 0);
      check("shadow_wr_okay", 32'(last_resp), 32'd0);
      for (int i = 0; i < 9; i++) read_check($sformatf("shadow%0d_r%0d", i, r), 6'(8 + 4 * i));
    end

    // Random FIFO strobes and W1C clears
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      fifo_underflow = 1'($urandom); fifo_overflow = 1'($urandom);
      sticky_m = sticky_m | {1'b0, fifo_underflow, fifo_overflow};
      @(negedge clk);
      fifo_underflow = 0; fifo_overflow = 0;
      read_check($sformatf("sticky_set_%0d", k), 6'h04);
      v = 3'($urandom); s = 4'($urandom);
      axi_write(6'h04, {29'b0, v}, s, 0);
      if (s[0]) sticky_m = sticky_m & ~v;
      read_check($sformatf("sticky_w1c_%0d", k), 6'h04);
    end
    axi_write(6'h04, 32'h7, 4'h1, 0);
    sticky_m = 3'b000;

    // Reset request with no ack: times out after 16 cycles
    axi_write(6'h00, 32'h2, 4'hF, 0);
    n = int'(last_rt0) + int'(last_rt1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reset_timer) n++;
      else break;
    end
    check("rst_timeout_len", 32'(n), 32'd16);
    sticky_m[2] = 1'b1; running_m = 1'b0;
    read_check("status_timeout", 6'h04);
    read_check("ctrl_after_timeout", 6'h00);
    axi_write(6'h04, 32'h4, 4'hF, 0);
    sticky_m[2] = 1'b0;
    read_check("status_cleared", 6'h04);

    // Reset request acknowledged after 3 cycles
    axi_write(6'h00, 32'h1, 4'hF, 0);
    running_m = 1'b1;
    axi_write(6'h00, 32'h2, 4'hF, 0);
    check("rst_req_high", 32'({last_rt0, last_rt1}), 32'b11);
    @(negedge clk);
    reset_ack = 1'b1;
    @(negedge clk);
    check("rst_req_dropped", 32'(reset_timer), 32'd0);
    axi_write(6'h00, 32'h2, 4'hF, 0);
    check("rst_second_ignored", 32'({last_rt0, last_rt1}), 32'b00);
    check("rst_second_okay", 32'(last_resp), 32'd0);
    pend_m = 1'b1;
    read_check("ctrl_wait_low", 6'h00);
    reset_ack = 1'b0;
    repeat (2) @(negedge clk);
    pend_m = 1'b0; running_m = 1'b0;
    read_check("ctrl_handshake_done", 6'h00);
    read_check("status_no_timeout", 6'h04);

    // Overflow set on the same edge as its W1C: set wins
    @(negedge clk); fifo_overflow = 1'b1;
    @(negedge clk); fifo_overflow = 1'b0;
    sticky_m[0] = 1'b1;
    pulse_ovf = 1'b1;
    axi_write(6'h04, 32'h1, 4'hF, 0);
    pulse_ovf = 1'b0;
    read_check("ovf_set_wins", 6'h04);
    axi_write(6'h04, 32'h1, 4'hF, 0);
    sticky_m[0] = 1'b0;
    read_check("ovf_cleared", 6'h04);

    // Trigger and reset in one write: trigger dropped
    axi_write(6'h00, 32'h3, 4'hF, 0);
    check("trig_dropped", 32'(last_trig0), 32'd0);
    check("rst_with_trig", 32'(last_rt0), 32'd1);
    @(negedge clk); reset_ack = 1'b1;
    repeat (2) @(negedge clk); reset_ack = 1'b0;
    repeat (2) @(negedge clk);
    read_check("ctrl_after_combo", 6'h00);

    // Unmapped space, ID write, AW without W
    read_check("unmapped_rd", 6'h34);
    axi_write(6'h38, 32'hFFFF_FFFF, 4'hF, 0);
    check("unmapped_wr_resp", 32'(last_resp), 32'd2);
    axi_write(6'h2C, 32'h1234_5678, 4'hF, 0);
    check("id_wr_resp", 32'(last_resp), 32'd0);
    read_check("id_after_wr", 6'h2C);
    axi_write(6'h00, 32'h0, 4'hF, 5);
    check("aw_waits_for_w", 32'(last_aw_early), 32'd0);

    // rst_n mid-transaction drops the pending response and clears state
    @(negedge clk);
    awaddr = 6'h04; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && !awready; k++) @(negedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("mid_bvalid", 32'(bvalid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid", 32'(bvalid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) shadow_m[i] = '0;
    sticky_m = 3'b000; running_m = 1'b0;
    read_check("post_rst_shadow3", 6'h14);
    read_check("post_rst_ctrl", 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
